// File: rtl/mips_pkg.sv
// Shared definitions for the mini-MIPS pipeline: opcode/funct codes, ALU op
// encoding and the ID/EX pipeline register bundle.
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_LUI = 4'd6
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   imm;
        logic              use_imm;
        logic [3:0]        alu_op;
        logic [RIDX_W-1:0] dst;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              illegal;
    } id_ex_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: control bits, immediate, ALU op,
// destination and which source registers the instruction actually reads.
module instr_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dst,
    output logic [31:0] imm,
    output logic [3:0]  alu_op,
    output logic        use_imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reads_rs,
    output logic        reads_rt,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] simm;
    logic [31:0] zimm;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign simm   = {{16{instr[15]}}, instr[15:0]};
    assign zimm   = {16'b0, instr[15:0]};

    always_comb begin
        // NOTE: every output is defaulted before the case so no path can infer a latch.
        dst       = instr[20:16];
        imm       = '0;
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reads_rs  = 1'b0;
        reads_rt  = 1'b0;
        illegal   = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                dst       = instr[15:11];
                reg_write = 1'b1;
                reads_rs  = 1'b1;
                reads_rt  = 1'b1;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    FN_SLL: begin
                        // Shift amount comes from shamt, so rs is not a source.
                        alu_op   = ALU_SLL;
                        use_imm  = 1'b1;
                        imm      = {27'b0, instr[10:6]};
                        reads_rs = 1'b0;
                    end
                    default: begin
                        illegal   = 1'b1;
                        reg_write = 1'b0;
                        reads_rs  = 1'b0;
                        reads_rt  = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                imm       = simm;
                use_imm   = 1'b1;
                reg_write = 1'b1;
                reads_rs  = 1'b1;
            end
            OP_LW: begin
                imm       = simm;
                use_imm   = 1'b1;
                reg_write = 1'b1;
                mem_read  = 1'b1;
                reads_rs  = 1'b1;
            end
            OP_SW: begin
                imm       = simm;
                use_imm   = 1'b1;
                mem_write = 1'b1;
                reads_rs  = 1'b1;
                reads_rt  = 1'b1;
            end
            OP_ANDI: begin
                alu_op    = ALU_AND;
                imm       = zimm;
                use_imm   = 1'b1;
                reg_write = 1'b1;
                reads_rs  = 1'b1;
            end
            OP_ORI: begin
                alu_op    = ALU_OR;
                imm       = zimm;
                use_imm   = 1'b1;
                reg_write = 1'b1;
                reads_rs  = 1'b1;
            end
            OP_LUI: begin
                alu_op    = ALU_LUI;
                imm       = {instr[15:0], 16'b0};
                use_imm   = 1'b1;
                reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, register-file index drive, EX/MEM and MEM/WB forwarding,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic [REG_AW-1:0] rf_rs,
    output logic [REG_AW-1:0] rf_rt,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              ex_stall_in,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_use_imm,
    output logic [3:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_illegal
);

    logic [4:0]  dec_rs, dec_rt, dec_dst;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_op;
    logic        dec_use_imm, dec_reg_write, dec_mem_read, dec_mem_write;
    logic        dec_reads_rs, dec_reads_rt, dec_illegal;

    instr_decoder u_decoder (
        .instr     (if_instr),
        .rs        (dec_rs),
        .rt        (dec_rt),
        .dst       (dec_dst),
        .imm       (dec_imm),
        .alu_op    (dec_alu_op),
        .use_imm   (dec_use_imm),
        .reg_write (dec_reg_write),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .reads_rs  (dec_reads_rs),
        .reads_rt  (dec_reads_rt),
        .illegal   (dec_illegal)
    );

    assign rf_rs = dec_rs;
    assign rf_rt = dec_rt;

    // The WB source is still needed: the register file only commits it at the edge.
    function automatic logic [XLEN-1:0] forward(
        input logic [RIDX_W-1:0] idx,
        input logic [XLEN-1:0]   rf_val,
        input logic              m_we,
        input logic [RIDX_W-1:0] m_rd,
        input logic [XLEN-1:0]   m_val,
        input logic              w_we,
        input logic [RIDX_W-1:0] w_rd,
        input logic [XLEN-1:0]   w_val
    );
        if (idx == '0)                    return '0;
        else if (m_we && (m_rd == idx))   return m_val;
        else if (w_we && (w_rd == idx))   return w_val;
        else                              return rf_val;
    endfunction

    id_ex_t id_ex_q;
    id_ex_t id_ex_d;
    logic   load_use;

    assign load_use = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.dst != '0) && if_valid &&
                      ((dec_reads_rs && (id_ex_q.dst == dec_rs)) ||
                       (dec_reads_rt && (id_ex_q.dst == dec_rt)));

    assign id_stall = !reset && !flush && (ex_stall_in || load_use);

    always_comb begin
        id_ex_d           = '0;
        id_ex_d.valid     = 1'b1;
        id_ex_d.pc        = if_pc;
        id_ex_d.op1       = forward(dec_rs, rf_rd1, mem_reg_write, mem_rd, mem_result,
                                    wb_reg_write, wb_rd, wb_data);
        id_ex_d.op2       = forward(dec_rt, rf_rd2, mem_reg_write, mem_rd, mem_result,
                                    wb_reg_write, wb_rd, wb_data);
        id_ex_d.imm       = dec_imm;
        id_ex_d.use_imm   = dec_use_imm;
        id_ex_d.alu_op    = dec_alu_op;
        id_ex_d.dst       = dec_dst;
        id_ex_d.reg_write = dec_reg_write;
        id_ex_d.mem_read  = dec_mem_read;
        id_ex_d.mem_write = dec_mem_write;
        id_ex_d.illegal   = dec_illegal;
    end

    // NOTE: state is updated with non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              id_ex_q <= '0;
        else if (flush)         id_ex_q <= '0;
        else if (ex_stall_in)   id_ex_q <= id_ex_q;
        else if (load_use)      id_ex_q <= '0;
        else if (if_valid)      id_ex_q <= id_ex_d;
        else                    id_ex_q <= '0;
    end

    assign ex_valid     = id_ex_q.valid;
    assign ex_pc        = id_ex_q.pc;
    assign ex_op1       = id_ex_q.op1;
    assign ex_op2       = id_ex_q.op2;
    assign ex_imm       = id_ex_q.imm;
    assign ex_use_imm   = id_ex_q.use_imm;
    assign ex_alu_op    = id_ex_q.alu_op;
    assign ex_dst       = id_ex_q.dst;
    assign ex_reg_write = id_ex_q.reg_write;
    assign ex_mem_read  = id_ex_q.mem_read;
    assign ex_mem_write = id_ex_q.mem_write;
    assign ex_illegal   = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes the ID/EX contents expected
// after each edge, a monitor pops and compares them just after that edge.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rf_rs, rf_rt;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_stall_in, flush;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_data;
    logic        id_stall, ex_valid, ex_use_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_dst;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_stall_in(ex_stall_in), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_use_imm(ex_use_imm), .ex_alu_op(ex_alu_op), .ex_dst(ex_dst),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, op1, op2, imm;
        logic        use_imm;
        logic [3:0]  alu;
        logic [4:0]  dst;
        logic        rw, mr, mw, ill;
        bit          chk_data;
        bit          chk_imm;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, op1, op2, imm, input logic use_imm,
                                input logic [3:0] alu, input logic [4:0] dst,
                                input logic rw, mr, mw);
        exp_t e;
        e.valid = 1'b1; e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm;
        e.use_imm = use_imm; e.alu = alu; e.dst = dst;
        e.rw = rw; e.mr = mr; e.mw = mw; e.ill = 1'b0;
        e.chk_data = 1'b1; e.chk_imm = 1'b1;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e.valid = 1'b0; e.chk_data = 1'b0; e.chk_imm = 1'b0;
        return e;
    endfunction

    function automatic exp_t illegal_exp();
        exp_t e;
        e = bub();
        e.valid = 1'b1; e.ill = 1'b1;
        return e;
    endfunction

    task automatic set_if(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v; if_instr = instr; if_pc = pc;
    endtask

    task automatic set_rf(input logic [31:0] d1, input logic [31:0] d2);
        rf_rd1 = d1; rf_rd2 = d2;
    endtask

    task automatic set_fwd(input logic mw, input logic [4:0] md, input logic [31:0] mv,
                           input logic ww, input logic [4:0] wd, input logic [31:0] wv);
        mem_reg_write = mw; mem_rd = md; mem_result = mv;
        wb_reg_write = ww; wb_rd = wd; wb_data = wv;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step(input exp_t e, input logic exp_stall, input string tag);
        #1;
        check({tag, " id_stall"}, id_stall, exp_stall);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Monitor: compare ID/EX just after each edge against the oldest expectation.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                check({t, " ex_valid"},     ex_valid,     e.valid);
                check({t, " ex_reg_write"}, ex_reg_write, e.rw);
                check({t, " ex_mem_read"},  ex_mem_read,  e.mr);
                check({t, " ex_mem_write"}, ex_mem_write, e.mw);
                check({t, " ex_illegal"},   ex_illegal,   e.ill);
                if (e.chk_data) begin
                    check({t, " ex_pc"},      ex_pc,      e.pc);
                    check({t, " ex_op1"},     ex_op1,     e.op1);
                    check({t, " ex_op2"},     ex_op2,     e.op2);
                    check({t, " ex_use_imm"}, ex_use_imm, e.use_imm);
                    check({t, " ex_alu_op"},  ex_alu_op,  e.alu);
                    check({t, " ex_dst"},     ex_dst,     e.dst);
                end
                if (e.chk_imm) check({t, " ex_imm"}, ex_imm, e.imm);
            end
        end
    end

    initial begin
        exp_t e, e_ori;

        reset = 1'b1; ex_stall_in = 1'b1; flush = 1'b0;
        set_if(1, 32'h0022502A, 32'h0);
        set_rf(0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        #3;
        check("rst ex_valid", ex_valid, 0);
        check("rst ex_illegal", ex_illegal, 0);
        check("rst ex_pc", ex_pc, 0);
        check("rst ex_op1", ex_op1, 0);
        check("rst ex_imm", ex_imm, 0);
        check("rst ex_reg_write", ex_reg_write, 0);
        check("rst id_stall", id_stall, 0);

        @(negedge clk);
        reset = 1'b0; ex_stall_in = 1'b0;
        set_if(1, 32'h20010005, 32'h100);
        set_rf(0, 32'h11);
        step(mk(32'h100, 0, 32'h11, 5, 1, 0, 1, 1, 0, 0), 0, "addi_pre");

        // Asynchronous reset in the middle of a cycle.
        set_if(1, 32'h3408F0F0, 32'h104);
        @(posedge clk);
        #1 check("pre_rst ex_valid", ex_valid, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst ex_valid", ex_valid, 0);
        check("async_rst ex_pc", ex_pc, 0);
        check("async_rst ex_imm", ex_imm, 0);
        check("async_rst ex_dst", ex_dst, 0);
        check("async_rst ex_reg_write", ex_reg_write, 0);
        check("async_rst ex_use_imm", ex_use_imm, 0);
        @(negedge clk);
        reset = 1'b0;
        set_if(1, 32'h20010005, 32'h108);
        step(mk(32'h108, 0, 32'h11, 5, 1, 0, 1, 1, 0, 0), 0, "addi");

        // Forwarding priority.
        set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
        set_rf(32'hCC, 32'hDD);
        set_if(1, 32'h00602020, 32'h200);
        e = mk(32'h200, 32'hAA, 0, 0, 0, 0, 4, 1, 0, 0); e.chk_imm = 0;
        step(e, 0, "fwd_mem");
        set_fwd(0, 3, 32'hAA, 1, 3, 32'hBB);
        set_if(1, 32'h00632022, 32'h204);
        e = mk(32'h204, 32'hBB, 32'hBB, 0, 0, 1, 4, 1, 0, 0); e.chk_imm = 0;
        step(e, 0, "fwd_wb");
        set_fwd(0, 3, 32'hAA, 1, 5, 32'hBB);
        set_if(1, 32'h00693825, 32'h208);
        e = mk(32'h208, 32'hCC, 32'hDD, 0, 0, 3, 7, 1, 0, 0); e.chk_imm = 0;
        step(e, 0, "fwd_none");

        // Load-use on rs, then on rt, then a non-reader.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_rf(32'h100, 32'h22);
        set_if(1, 32'h8C220008, 32'h300);
        step(mk(32'h300, 32'h100, 32'h22, 8, 1, 0, 2, 1, 1, 0), 0, "lw");
        set_if(1, 32'h00462820, 32'h304);
        step(bub(), 1, "lu_bubble");
        set_fwd(1, 2, 32'h1234, 0, 0, 0);
        set_rf(32'h999, 32'h66);
        e = mk(32'h304, 32'h1234, 32'h66, 0, 0, 0, 5, 1, 0, 0); e.chk_imm = 0;
        step(e, 0, "lu_add");
        set_fwd(0, 0, 0, 0, 0, 0);
        set_rf(32'h100, 32'h22);
        set_if(1, 32'h8C220008, 32'h308);
        step(mk(32'h308, 32'h100, 32'h22, 8, 1, 0, 2, 1, 1, 0), 0, "lw2");
        set_if(1, 32'hAC020004, 32'h30C);
        step(bub(), 1, "sw_bubble");
        set_fwd(0, 0, 0, 1, 2, 32'h5555);
        step(mk(32'h30C, 0, 32'h5555, 4, 1, 0, 2, 0, 0, 1), 0, "sw");
        set_fwd(0, 0, 0, 0, 0, 0);
        set_if(1, 32'h8C220008, 32'h310);
        step(mk(32'h310, 32'h100, 32'h22, 8, 1, 0, 2, 1, 1, 0), 0, "lw3");
        set_if(1, 32'h3C421234, 32'h314);
        step(mk(32'h314, 32'h100, 32'h22, 32'h12340000, 1, 6, 2, 1, 0, 0), 0, "lui_no_stall");

        // Downstream stall holds ID/EX.
        set_if(1, 32'h3408F0F0, 32'h400);
        e_ori = mk(32'h400, 0, 32'h22, 32'hF0F0, 1, 3, 8, 1, 0, 0);
        step(e_ori, 0, "ori");
        ex_stall_in = 1'b1;
        set_if(1, 32'h31098000, 32'h404);
        set_rf(32'h77, 32'h88);
        for (int i = 0; i < 3; i++) step(e_ori, 1, $sformatf("hold%0d", i));
        ex_stall_in = 1'b0;
        step(mk(32'h404, 32'h77, 32'h88, 32'h8000, 1, 2, 9, 1, 0, 0), 0, "andi");

        // Flush beats stall and hazard; invalid IF/ID loads a bubble.
        set_rf(32'h100, 32'h22);
        set_if(1, 32'h8C220008, 32'h500);
        step(mk(32'h500, 32'h100, 32'h22, 8, 1, 0, 2, 1, 1, 0), 0, "lw5");
        flush = 1'b1; ex_stall_in = 1'b1;
        set_if(1, 32'h00462820, 32'h504);
        step(bub(), 0, "flush");
        flush = 1'b0; ex_stall_in = 1'b0;
        set_if(0, 32'h0022502A, 32'h508);
        #1;
        check("rf_rs invalid", rf_rs, 1);
        check("rf_rt invalid", rf_rt, 2);
        @(negedge clk);
        step(bub(), 0, "invalid");

        // Illegal encodings and immediate extension.
        set_if(1, 32'hFC221234, 32'h600);
        step(illegal_exp(), 0, "ill_op");
        set_if(1, 32'h00221827, 32'h604);
        step(illegal_exp(), 0, "ill_fn");
        set_if(1, 32'h20018000, 32'h608);
        step(mk(32'h608, 0, 32'h22, 32'hFFFF8000, 1, 0, 1, 1, 0, 0), 0, "addi_neg");
        set_if(1, 32'h0022502A, 32'h60C);
        e = mk(32'h60C, 32'h100, 32'h22, 0, 0, 4, 10, 1, 0, 0); e.chk_imm = 0;
        step(e, 0, "slt");
        set_if(1, 32'h000259C0, 32'h610);
        step(mk(32'h610, 0, 32'h22, 7, 1, 5, 11, 1, 0, 0), 0, "sll");
        set_if(0, 32'h0, 32'h614);
        step(bub(), 0, "tail");

        @(negedge clk);
        check("scoreboard drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
